// File: rtl/load_pulse_gen.sv
// Load push-button conditioner: two-flop synchroniser, stable-sample debouncer,
// and a single Load (or denial) strobe per accepted press.
module load_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic logged_in,
    output logic load_pulse,
    output logic denied_pulse,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sync1;
    logic             sync2;
    logic             accept;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync2) begin
                    state_nxt = REL_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            REL_WAIT: begin
                // A high sample here is release bounce: fall back to HELD without a new strobe.
                if (sync2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            load_pulse   <= 1'b0;
            denied_pulse <= 1'b0;
            btn_level    <= 1'b0;
        end else begin
            sync1        <= btn_raw;
            sync2        <= sync1;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            // logged_in matters only on the accepting edge.
            load_pulse   <= accept & logged_in;
            denied_pulse <= accept & ~logged_in;
            btn_level    <= (state_nxt == HELD) || (state_nxt == REL_WAIT);
        end
    end

endmodule

// File: tb/tb_load_pulse_gen.sv
// Bench for load_pulse_gen: directed test-plan scenarios plus randomized button
// activity, all checked every cycle against a run-length debounce model.
module tb_load_pulse_gen;

    localparam int D = 4;

    logic clk;
    logic rst;
    logic btn_raw;
    logic logged_in;
    logic load_pulse;
    logic denied_pulse;
    logic btn_level;

    int n_vec;
    int n_bad;
    int load_cnt;
    int denied_cnt;

    // Model: debounced level flips after D consecutive synchronised samples disagreeing with it.
    logic m_s1;
    logic m_s2;
    logic m_level;
    int   m_run;
    logic exp_load;
    logic exp_denied;

    load_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .logged_in   (logged_in),
        .load_pulse  (load_pulse),
        .denied_pulse(denied_pulse),
        .btn_level   (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_vec = n_vec + 1;
        if (actual !== expected) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        n_vec = n_vec + 1;
        if (actual != expected) begin
            n_bad = n_bad + 1;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1       <= 1'b0;
            m_s2       <= 1'b0;
            m_level    <= 1'b0;
            m_run      <= 0;
            exp_load   <= 1'b0;
            exp_denied <= 1'b0;
        end else begin
            m_s1 <= btn_raw;
            m_s2 <= m_s1;
            if ((m_s2 != m_level) && (m_run + 1 == D)) begin
                m_level    <= m_s2;
                m_run      <= 0;
                exp_load   <= m_s2 & logged_in;
                exp_denied <= m_s2 & ~logged_in;
            end else begin
                m_run      <= (m_s2 != m_level) ? m_run + 1 : 0;
                exp_load   <= 1'b0;
                exp_denied <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check_output("load_pulse", load_pulse, exp_load);
        check_output("denied_pulse", denied_pulse, exp_denied);
        check_output("btn_level", btn_level, m_level);
        if (load_pulse === 1'b1) load_cnt <= load_cnt + 1;
        if (denied_pulse === 1'b1) denied_cnt <= denied_cnt + 1;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic b, input int n);
        @(negedge clk);
        btn_raw = b;
        if (n > 1) idle_cycles(n - 1);
    endtask

    initial begin
        int p0;
        int d0;
        n_vec      = 0;
        n_bad      = 0;
        load_cnt   = 0;
        denied_cnt = 0;
        rst        = 1'b0;
        btn_raw    = 1'b0;
        logged_in  = 1'b0;
        #2;
        check_output("reset_load", load_pulse, 1'b0);
        check_output("reset_denied", denied_pulse, 1'b0);
        check_output("reset_level", btn_level, 1'b0);
        idle_cycles(3);
        rst = 1'b1;
        idle_cycles(3);

        // Clean press while logged in.
        p0 = load_cnt;
        @(negedge clk);
        logged_in = 1'b1;
        btn_raw   = 1'b1;
        repeat (D + 1) @(posedge clk);
        #1 check_output("clean_pre_pulse", load_pulse, 1'b0);
        @(posedge clk);
        #1 check_output("clean_pulse", load_pulse, 1'b1);
        check_output("clean_level_up", btn_level, 1'b1);
        check_output("clean_no_denied", denied_pulse, 1'b0);
        @(posedge clk);
        #1 check_output("clean_pulse_end", load_pulse, 1'b0);
        idle_cycles(12);
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (D + 1) @(posedge clk);
        #1 check_output("clean_level_hold", btn_level, 1'b1);
        @(posedge clk);
        #1 check_output("clean_level_down", btn_level, 1'b0);
        idle_cycles(4);
        check_count("clean_pulse_total", load_cnt - p0, 1);

        // Input bounce on press.
        p0 = load_cnt;
        apply_stimulus(1'b1, 1);
        apply_stimulus(1'b0, 1);
        apply_stimulus(1'b1, 1);
        apply_stimulus(1'b0, 1);
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (D + 1) @(posedge clk);
        #1 check_count("bounce_no_early_pulse", load_cnt - p0, 0);
        @(posedge clk);
        #1 check_output("bounce_pulse", load_pulse, 1'b1);
        idle_cycles(8);

        // Release bounce while held.
        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 1);
        repeat (8) begin
            @(negedge clk);
            check_output("glitch_level", btn_level, 1'b1);
        end
        idle_cycles(2);
        apply_stimulus(1'b0, 12);
        check_count("bounce_pulse_total", load_cnt - p0, 1);

        // Logged out press, then log in while held.
        p0 = load_cnt;
        d0 = denied_cnt;
        @(negedge clk);
        logged_in = 1'b0;
        btn_raw   = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 check_output("denied_pulse_hit", denied_pulse, 1'b1);
        check_output("denied_no_load", load_pulse, 1'b0);
        @(negedge clk);
        logged_in = 1'b1;
        idle_cycles(10);
        check_count("denied_total", denied_cnt - d0, 1);
        check_count("login_while_held", load_cnt - p0, 0);

        // Asynchronous reset while held clears btn_level at once.
        #2 rst = 1'b0;
        #1 check_output("held_reset_level", btn_level, 1'b0);
        idle_cycles(2);
        btn_raw = 1'b0;
        rst     = 1'b1;
        idle_cycles(10);

        // Reset in PRESS_WAIT with cnt=2, button kept high through release.
        p0 = load_cnt;
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_output("midpress_reset_load", load_pulse, 1'b0);
        check_output("midpress_reset_level", btn_level, 1'b0);
        idle_cycles(3);
        rst = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 check_output("post_reset_pulse", load_pulse, 1'b1);
        idle_cycles(5);
        apply_stimulus(1'b0, 10);
        check_count("post_reset_total", load_cnt - p0, 1);

        // Back-to-back presses.
        p0 = load_cnt;
        repeat (3) begin
            apply_stimulus(1'b1, 10);
            apply_stimulus(1'b0, 10);
        end
        check_count("back_to_back_total", load_cnt - p0, 3);

        // Randomized activity, including occasional asynchronous resets.
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                @(negedge clk);
                #2 rst = 1'b0;
                idle_cycles(int'($urandom_range(1, 3)));
                rst = 1'b1;
            end else if (sel < 4) begin
                @(negedge clk);
                logged_in = ~logged_in;
            end else if (sel < 12) begin
                apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            end else begin
                apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(4, 12)));
            end
        end
        idle_cycles(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
